// File: rtl/input4_nand_b_checker_pkg.sv
// Shared definitions for the input4_nand_b on-chip checker.
// Holds the FSM state encoding, the sweep geometry and the default truth
// tables of the gate block (bit i of a table = expected output for vector i,
// vector index = {a,b,c,d}).
package input4_nand_pkg;

   localparam int NUM_VEC = 16;
   localparam int VEC_W   = 4;

   localparam logic [NUM_VEC-1:0] NAND4_TT   = 16'h7FFF;  // ~(a&b&c&d)
   localparam logic [NUM_VEC-1:0] NAND_AB_TT = 16'h0FFF;  // ~(a&b)
   localparam logic [NUM_VEC-1:0] NAND_CD_TT = 16'h7777;  // ~(c&d)

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Expected {e,f,g} for one vector index.
   function automatic logic [2:0] expected_efg(input logic [NUM_VEC-1:0] tt_e,
                                               input logic [NUM_VEC-1:0] tt_f,
                                               input logic [NUM_VEC-1:0] tt_g,
                                               input logic [VEC_W-1:0]   idx);
      return {tt_e[idx], tt_f[idx], tt_g[idx]};
   endfunction

endpackage

// File: rtl/input4_nand_b_checker_if.sv
// Stimulus/response bus between the checker and the input4_nand_b gate block.
//   a,b,c,d : stimulus from the checker ({a,b,c,d} = vector index, a is MSB)
//   e,f,g   : gate block outputs observed by the checker
// master = checker side, slave = gate block side.
interface input4_nand_b_checker_if;
   logic a;
   logic b;
   logic c;
   logic d;
   logic e;
   logic f;
   logic g;

   modport master (output a, b, c, d, input e, f, g);
   modport slave  (input a, b, c, d, output e, f, g);
endinterface

// File: rtl/input4_hold_timer.sv
// Hold-window timer for the checker sweep.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the window count at zero
//   en         : count while a sweep is running
//   win_end    : high during the last cycle of a hold window (sample cycle)
module input4_hold_timer #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic win_end
);

   localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);

   logic [7:0] hold_cnt;

   assign win_end = en && (hold_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
      end else if (clr || win_end) begin
         hold_cnt <= '0;
      end else if (en) begin
         hold_cnt <= hold_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/input4_nand_b_checker.sv
// On-chip stimulus/response checker for the input4_nand_b gate block.
// Sweeps all 16 {a,b,c,d} vectors in binary order, holds each for
// HOLD_CYCLES cycles, samples {e,f,g} in the last cycle of each hold window
// and compares against the EXP_* truth tables.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : one-cycle sweep request (ignored while busy)
//   gate           : stimulus/response bus to the gate block (master side)
//   busy           : sweep in progress
//   done           : sweep complete, results valid until the next start
//   pass           : 1 when the completed sweep saw no mismatch
//   err_count      : number of mismatching vectors (0..16)
//   fail_seen      : at least one mismatch seen
//   first_fail_vec : index of the first mismatching vector
module input4_nand_b_checker
   import input4_nand_pkg::*;
#(
   parameter int                 HOLD_CYCLES = 4,
   parameter logic [NUM_VEC-1:0] EXP_E       = NAND4_TT,
   parameter logic [NUM_VEC-1:0] EXP_F       = NAND_AB_TT,
   parameter logic [NUM_VEC-1:0] EXP_G       = NAND_CD_TT
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input4_nand_b_checker_if.master        gate,
   output logic                           busy,
   output logic                           done,
   output logic                           pass,
   output logic [4:0]                     err_count,
   output logic                           fail_seen,
   output logic [VEC_W-1:0]               first_fail_vec
);

   localparam logic [VEC_W-1:0] LAST_VEC = '1;

   state_t           state;
   logic [VEC_W-1:0] vec;
   logic             launch;
   logic             win_end;
   logic             mismatch;

   // Stimulus comes straight from the vector register, so a..d are flop outputs.
   assign gate.a = vec[3];
   assign gate.b = vec[2];
   assign gate.c = vec[1];
   assign gate.d = vec[0];

   assign launch = start && (state != ST_RUN);

   input4_hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (launch),
      .en      (state == ST_RUN),
      .win_end (win_end)
   );

   // Written as if/else so an unknown on e/f/g falls into the mismatch branch.
   always_comb begin
      mismatch = 1'b1;
      if ({gate.e, gate.f, gate.g} == expected_efg(EXP_E, EXP_F, EXP_G, vec)) begin
         mismatch = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         vec            <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         fail_seen      <= 1'b0;
         first_fail_vec <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state          <= ST_RUN;
                  vec            <= '0;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  err_count      <= '0;
                  fail_seen      <= 1'b0;
                  first_fail_vec <= '0;
               end
            end
            ST_RUN: begin
               if (win_end) begin
                  if (mismatch) begin
                     err_count <= err_count + 5'd1;
                     if (!fail_seen) begin
                        fail_seen      <= 1'b1;
                        first_fail_vec <= vec;
                     end
                  end
                  if (vec != LAST_VEC) begin
                     vec <= vec + 1'b1;
                  end else begin
                     // Final verdict must include the vector being sampled now.
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_count == 5'd0) && !mismatch;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_input4_nand_b_checker.sv
// Bench for input4_nand_b_checker: two instances (HOLD_CYCLES 4 and 2) driving
// a behavioural gate model with selectable faults.
module tb_input4_nand_b_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n4, rst_n2, start4, start2;
   logic       busy4, done4, pass4, fs4;
   logic       busy2, done2, pass2, fs2;
   logic [4:0] ec4, ec2;
   logic [3:0] ffv4, ffv2;

   input4_nand_b_checker_if if4 ();
   input4_nand_b_checker_if if2 ();

   input4_nand_b_checker #(.HOLD_CYCLES(4)) dut4 (
      .clk(clk), .rst_n(rst_n4), .start(start4), .gate(if4),
      .busy(busy4), .done(done4), .pass(pass4), .err_count(ec4),
      .fail_seen(fs4), .first_fail_vec(ffv4));

   input4_nand_b_checker #(.HOLD_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n2), .start(start2), .gate(if2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(ec2),
      .fail_seen(fs2), .first_fail_vec(ffv2));

   // Gate model: 0 = correct, 1 = e stuck at 1, 2 = f inverted, 3 = per-vector flips.
   int         mode = 0;
   logic [2:0] flip_tbl [16];

   function automatic logic [2:0] gate_model(input logic [3:0] v, input int m,
                                             input logic [2:0] flp);
      logic ge, gf, gg;
      ge = !(v == 4'hF);
      gf = !(v[3] && v[2]);
      gg = !(v[1] && v[0]);
      if (m == 1) ge = 1'b1;
      if (m == 2) gf = !gf;
      if (m == 3) return {ge, gf, gg} ^ flp;
      return {ge, gf, gg};
   endfunction

   logic [3:0] v4, v2;
   assign v4 = {if4.a, if4.b, if4.c, if4.d};
   assign v2 = {if2.a, if2.b, if2.c, if2.d};
   assign {if4.e, if4.f, if4.g} = gate_model(v4, mode, flip_tbl[v4]);
   assign {if2.e, if2.f, if2.g} = gate_model(v2, mode, flip_tbl[v2]);

   // Instance selection for the shared scenario tasks.
   int         sel = 0;
   logic       c_busy, c_done, c_pass, c_fs;
   logic [4:0] c_ec;
   logic [3:0] c_ffv, c_vec;
   always_comb begin
      if (sel == 0) begin
         c_busy = busy4; c_done = done4; c_pass = pass4; c_fs = fs4;
         c_ec = ec4; c_ffv = ffv4; c_vec = v4;
      end else begin
         c_busy = busy2; c_done = done2; c_pass = pass2; c_fs = fs2;
         c_ec = ec2; c_ffv = ffv2; c_vec = v2;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic set_start(input logic val);
      if (sel == 0) start4 = val; else start2 = val;
   endtask

   // One full sweep from start to done, with the expected results derived
   // from the gate model vs. the ideal NAND behaviour.
   task automatic run_sweep(input string name, input int m, input int mid_vec);
      int hold, k, exp_err, exp_first, bad_cycles;
      logic exp_fs;
      hold = (sel == 0) ? 4 : 2;
      mode = m;
      exp_err = 0; exp_first = 0; exp_fs = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (gate_model(4'(i), m, flip_tbl[i]) != gate_model(4'(i), 0, 3'b000)) begin
            if (!exp_fs) begin exp_fs = 1'b1; exp_first = i; end
            exp_err++;
         end
      end
      @(negedge clk); set_start(1'b1);
      @(negedge clk); set_start(1'b0);
      n_tests++;
      if ({c_busy, c_done, c_pass, c_ec, c_fs} !== {1'b1, 1'b0, 1'b0, 5'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL %s_launch: busy/done/pass/err/fs=%b %b %b %0d %b, want 1 0 0 0 0",
                  name, c_busy, c_done, c_pass, c_ec, c_fs);
      end
      k = 0; bad_cycles = 0;
      while (!c_done && k < 200) begin
         set_start(1'b0);
         if (c_vec !== 4'(k / hold) || c_busy !== 1'b1) bad_cycles++;
         if (mid_vec >= 0 && k == mid_vec * hold) set_start(1'b1);
         @(negedge clk);
         k++;
      end
      set_start(1'b0);
      n_tests++;
      if (bad_cycles != 0) begin
         n_fail++;
         $display("FAIL %s_stimulus: %0d cycles with wrong vector/busy, want 0", name, bad_cycles);
      end
      n_tests++;
      if (k != 16 * hold) begin
         n_fail++;
         $display("FAIL %s_duration: done after %0d cycles, want %0d", name, k, 16 * hold);
      end
      n_tests++;
      if (c_ec !== 5'(exp_err) || c_fs !== exp_fs || c_ffv !== 4'(exp_first)) begin
         n_fail++;
         $display("FAIL %s_results: err=%0d fs=%b first=%0d, want err=%0d fs=%b first=%0d",
                  name, c_ec, c_fs, c_ffv, exp_err, exp_fs, exp_first);
      end
      n_tests++;
      if (c_pass !== (exp_err == 0) || c_busy !== 1'b0 || c_done !== 1'b1 || c_vec !== 4'hF) begin
         n_fail++;
         $display("FAIL %s_final: pass=%b busy=%b done=%b vec=%h, want pass=%b busy=0 done=1 vec=f",
                  name, c_pass, c_busy, c_done, c_vec, exp_err == 0);
      end
   endtask

   task automatic test_reset();
      rst_n4 = 1'b0; rst_n2 = 1'b0; start4 = 1'b0; start2 = 1'b0;
      for (int i = 0; i < 16; i++) flip_tbl[i] = 3'b000;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({busy4, done4, pass4, fs4, ec4, ffv4, v4, busy2, done2, pass2, fs2, ec2, ffv2, v2} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: dut4 %b%b%b%b %0d %h %h dut2 %b%b%b%b %0d %h %h, want all 0",
                  busy4, done4, pass4, fs4, ec4, ffv4, v4, busy2, done2, pass2, fs2, ec2, ffv2, v2);
      end
      rst_n4 = 1'b1; rst_n2 = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_sweep();
      int k, idle_bad;
      sel = 0; mode = 0;
      @(negedge clk); start4 = 1'b1;
      @(negedge clk); start4 = 1'b0;
      k = 0;
      while (v4 != 4'd9 && k < 200) begin @(negedge clk); k++; end
      n_tests++;
      if (v4 !== 4'd9) begin
         n_fail++;
         $display("FAIL rst_reach_vec9: vec=%h, want 9", v4);
      end
      rst_n4 = 1'b0;
      #1;
      n_tests++;
      if ({busy4, done4, pass4, fs4, ec4, ffv4, v4} !== '0) begin
         n_fail++;
         $display("FAIL rst_async: busy=%b done=%b pass=%b fs=%b err=%0d first=%h vec=%h, want all 0",
                  busy4, done4, pass4, fs4, ec4, ffv4, v4);
      end
      @(negedge clk); rst_n4 = 1'b1;
      idle_bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy4 !== 1'b0 || done4 !== 1'b0 || v4 !== 4'h0 || ec4 !== 5'd0) idle_bad++;
      end
      n_tests++;
      if (idle_bad != 0) begin
         n_fail++;
         $display("FAIL rst_idle: %0d cycles with activity after reset, want 0", idle_bad);
      end
   endtask

   task automatic test_random_faults();
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 16; i++) flip_tbl[i] = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
         sel = r % 2;
         run_sweep("random", 3, -1);
      end
      for (int i = 0; i < 16; i++) flip_tbl[i] = 3'b000;
      flip_tbl[15] = 3'b001;
      sel = 1;
      run_sweep("last_only_g", 3, -1);
   endtask

   initial begin
      test_reset();
      sel = 0;
      run_sweep("good_h4", 0, -1);
      run_sweep("e_stuck1", 1, -1);
      run_sweep("f_inverted", 2, -1);
      run_sweep("mid_start", 0, 7);
      test_reset_mid_sweep();
      sel = 0;
      run_sweep("after_reset", 0, -1);
      sel = 1;
      run_sweep("good_h2", 0, -1);
      run_sweep("f_inverted_h2", 2, -1);
      test_random_faults();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/input4_nand_b_checker.md
Name: input4_nand_b_checker

Overview:
- Synthesizable stimulus/response engine for the input4_nand_b gate block; it drives the block on-chip so it can be tested in hardware.
- Steps all 16 {a,b,c,d} input combinations in binary order and holds each for a programmable number of cycles.
- Samples the block's e,f,g outputs at the end of each hold window and compares them against parameterized truth tables.
- Reports mismatch count, first failing vector and a pass/done summary.

Parameters:
- HOLD_CYCLES, 4, cycles each vector is driven (legal range 2..255).
- EXP_E, 16'h7FFF, expected e per vector index (bit i = expected e for vec i); 4-input NAND.
- EXP_F, 16'h0FFF, expected f per vector index; NAND(a,b).
- EXP_G, 16'h7777, expected g per vector index; NAND(c,d).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep.
- e  in  1  observed output e from input4_nand_b.
- f  in  1  observed output f from input4_nand_b.
- g  in  1  observed output g from input4_nand_b.
- a  out  1  stimulus a, registered; MSB of the vector index.
- b  out  1  stimulus b, registered.
- c  out  1  stimulus c, registered.
- d  out  1  stimulus d, registered; LSB of the vector index.
- busy  out  1  high while a sweep is running.
- done  out  1  high from sweep completion until the next start.
- pass  out  1  valid when done=1; 1 when err_count==0.
- err_count  out  5  number of mismatching vectors, 0..16.
- fail_seen  out  1  set at the first mismatch.
- first_fail_vec  out  4  vector index of the first mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - a,b,c,d, busy, done, pass, fail_seen = 0; err_count = 0; first_fail_vec = 0.
  - Internal vec and hold_cnt = 0.
  - Applies immediately, including mid-sweep; no partial results are kept.
- States:
  - IDLE: waits for start.
  - RUN: drives the current vector.
  - DONE: holds the results.
- IDLE or DONE with start=1 at an edge:
  - Next state RUN; vec=0, hold_cnt=0, {a,b,c,d}=4'b0000.
  - busy=1, done=0, pass=0.
  - err_count=0, fail_seen=0, first_fail_vec=0.
- RUN, per cycle:
  - {a,b,c,d} always equals vec.
  - hold_cnt increments each edge while hold_cnt < HOLD_CYCLES-1.
- RUN, sample edge (hold_cnt == HOLD_CYCLES-1):
  - Compare {e,f,g} with {EXP_E[vec],EXP_F[vec],EXP_G[vec]}.
  - On mismatch: err_count += 1. If fail_seen=0, set fail_seen=1 and first_fail_vec=vec.
  - If vec != 15: vec += 1 and hold_cnt = 0.
  - If vec == 15: next state DONE; busy=0, done=1; pass = (final err_count == 0), including a mismatch on vector 15 itself.
- Timing:
  - A sweep lasts exactly 16*HOLD_CYCLES cycles from the start edge to the done edge (64 at the default).
  - Each vector is applied for HOLD_CYCLES-1 settle cycles before it is sampled.
- start while in RUN: ignored; the sweep continues undisturbed.
- DONE: outputs hold their values; a,b,c,d stay at 4'b1111 until the next start.
- Inputs e,f,g are used directly; the upstream block is combinational from this block's registered outputs.
- err_count is 5 bits, so its maximum of 16 cannot overflow.
- X on e,f,g counts as a mismatch in simulation; no special handling in RTL.

Decomposition:
- Package input4_nand_pkg holds:
  - state encoding (IDLE, RUN, DONE);
  - NUM_VEC=16;
  - VEC_W=4;
  - default truth-table constants NAND4_TT=16'h7FFF, NAND_AB_TT=16'h0FFF, NAND_CD_TT=16'h7777.
- One sub-module, input4_hold_timer: hold_cnt with a clear input and a "window end" pulse output. Everything else stays flat.

Test Plan:
- Correct DUT model, HOLD_CYCLES=4, start pulse at cycle 10 -> busy for 64 cycles; done=1 at cycle 74; pass=1, err_count=0, fail_seen=0; a..d step through 0..15, each held for 4 cycles.
- Model with e stuck at 1 -> only vec 15 mismatches; err_count=1, first_fail_vec=4'hF, pass=0.
- Model with f inverted -> err_count=16, first_fail_vec=0, fail_seen=1, pass=0.
- Start pulsed again at vec 7 mid-sweep -> ignored; done still exactly 64 cycles after the first start. A later start in DONE clears err_count/done/pass and reruns.
- rst_n low for 1 cycle at vec 9 -> all outputs 0 immediately; IDLE; no activity until the next start.
- HOLD_CYCLES=2 -> sweep completes in 32 cycles; each compare occurs on the second cycle of its vector.
